// File: rtl/wb_uart_fifo_top.sv
// Wishbone-slave UART with TX/RX FIFOs, runtime baud divisor, optional parity,
// sticky error flags and a registered level interrupt.

module wb_uart_fifo_buf #(
    parameter int unsigned p_DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_srst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [7:0]               iv_din,
    output logic [7:0]               ov_dout,
    output logic [$clog2(p_DEPTH):0] ov_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int unsigned AW = $clog2(p_DEPTH);

    logic [7:0]    mem [p_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_en, rd_en;

    assign o_empty = (ov_count == '0);
    assign o_full  = (ov_count == (AW+1)'(p_DEPTH));
    assign rd_en   = i_pop & ~o_empty;
    // a pop in the same cycle frees the slot, so a push on full still lands
    assign wr_en   = i_push & (~o_full | rd_en);
    assign ov_dout = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= iv_din;
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ov_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en & ~rd_en)      ov_count <= ov_count + (AW+1)'(1);
            else if (rd_en & ~wr_en) ov_count <= ov_count - (AW+1)'(1);
        end
    end
endmodule

module wb_uart_fifo_top #(
    parameter int unsigned p_FDEPTH = 16,
    parameter int unsigned p_FREQ   = 50_000_000,
    parameter int unsigned p_BAUD   = 115200
) (
    input  logic        i_clk,
    input  logic        i_srst,
    input  logic [3:0]  iv_wbs_adr,
    input  logic [31:0] iv_wbs_dat,
    input  logic        i_wbs_we,
    input  logic        i_wbs_stb,
    input  logic [3:0]  iv_wbs_sel,
    input  logic        i_wbs_cyc,
    output logic [31:0] ov_wbs_dat,
    output logic        o_wbs_ack,
    input  logic        i_uart_rxd,
    output logic        o_uart_txd,
    output logic        o_irq
);
    localparam int unsigned CW      = $clog2(p_FDEPTH) + 1;
    localparam logic [15:0] DIV_RST = 16'(p_FREQ / p_BAUD);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    logic        wb_access, wr_data, rd_data, wr_ctrl, wr_err;
    logic [31:0] rd_mux;
    logic [15:0] div;
    logic        par_en, par_odd, ie_rxne, ie_txe, ie_err;
    logic [3:0]  err;

    logic [7:0]    tx_fifo_dout, rx_fifo_dout;
    logic [CW-1:0] tx_count, rx_count, tx_free;
    logic          tx_full, tx_fifo_empty, rx_full, rx_fifo_empty, rx_ne, rx_pop;

    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bitn;
    logic [7:0]  tx_shift;
    logic        tx_par_en, tx_par_bit, tx_bit_end, tx_load, tx_busy, tx_ovf_set;

    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_div;
    logic [2:0]  rx_bitn;
    logic [7:0]  rx_shift;
    logic        rxd_s1, rxd_s2, rxd_prev, rx_fall, rx_tick;
    logic        rx_par_en, rx_par_odd, rx_par_bit;
    logic        rx_push, rx_frame_err, rx_par_err, rx_ovf_set;

    logic unused_bits;
    assign unused_bits = ^{iv_wbs_sel, iv_wbs_adr[1:0], iv_wbs_dat[31:23], iv_wbs_dat[19:18]};

    assign wb_access = i_wbs_cyc & i_wbs_stb & ~o_wbs_ack;
    assign wr_data   = wb_access &  i_wbs_we & (iv_wbs_adr[3:2] == 2'd0);
    assign rd_data   = wb_access & ~i_wbs_we & (iv_wbs_adr[3:2] == 2'd0);
    assign wr_ctrl   = wb_access &  i_wbs_we & (iv_wbs_adr[3:2] == 2'd2);
    assign wr_err    = wb_access &  i_wbs_we & (iv_wbs_adr[3:2] == 2'd3);

    assign rx_ne      = ~rx_fifo_empty;
    assign rx_pop     = rd_data & rx_ne;
    assign tx_busy    = (tx_state != TX_IDLE);
    assign tx_free    = CW'(p_FDEPTH) - tx_count;
    assign tx_ovf_set = wr_data & tx_full & ~tx_load;
    assign rx_ovf_set = rx_push & rx_full & ~rx_pop;
    assign rx_fall    = rxd_prev & ~rxd_s2;

    wb_uart_fifo_buf #(.p_DEPTH(p_FDEPTH)) u_tx_fifo (
        .i_clk(i_clk), .i_srst(i_srst), .i_push(wr_data), .i_pop(tx_load),
        .iv_din(iv_wbs_dat[7:0]), .ov_dout(tx_fifo_dout), .ov_count(tx_count),
        .o_full(tx_full), .o_empty(tx_fifo_empty)
    );

    wb_uart_fifo_buf #(.p_DEPTH(p_FDEPTH)) u_rx_fifo (
        .i_clk(i_clk), .i_srst(i_srst), .i_push(rx_push), .i_pop(rd_data),
        .iv_din(rx_shift), .ov_dout(rx_fifo_dout), .ov_count(rx_count),
        .o_full(rx_full), .o_empty(rx_fifo_empty)
    );

    always_comb begin
        rd_mux = '0;
        case (iv_wbs_adr[3:2])
            2'd0:    rd_mux = {rx_ne, 23'd0, rx_ne ? rx_fifo_dout : 8'h00};
            2'd1:    rd_mux = {8'd0, 8'(tx_free), 8'(rx_count), 4'd0,
                               tx_busy, tx_fifo_empty, tx_full, rx_ne};
            2'd2:    rd_mux = {9'd0, ie_err, ie_txe, ie_rxne, 2'd0, par_odd, par_en, div};
            default: rd_mux = {28'd0, err};
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            o_wbs_ack  <= 1'b0;
            ov_wbs_dat <= '0;
            div        <= DIV_RST;
            {par_en, par_odd, ie_rxne, ie_txe, ie_err} <= '0;
            err        <= '0;
            o_irq      <= 1'b0;
        end else begin
            o_wbs_ack  <= wb_access;
            ov_wbs_dat <= (wb_access & ~i_wbs_we) ? rd_mux : '0;
            if (wr_ctrl) begin
                div     <= (iv_wbs_dat[15:0] < 16'd4) ? 16'd4 : iv_wbs_dat[15:0];
                par_en  <= iv_wbs_dat[16];
                par_odd <= iv_wbs_dat[17];
                ie_rxne <= iv_wbs_dat[20];
                ie_txe  <= iv_wbs_dat[21];
                ie_err  <= iv_wbs_dat[22];
            end
            err   <= (err & ~(wr_err ? iv_wbs_dat[3:0] : 4'd0))
                   | {tx_ovf_set, rx_par_err, rx_frame_err, rx_ovf_set};
            o_irq <= (ie_rxne & rx_ne) | (ie_txe & tx_fifo_empty & ~tx_busy) | (ie_err & |err);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) tx_state <= TX_IDLE;
        else        tx_state <= tx_state_n;
    end

    // STOP reloads straight into START when data is waiting, so frames run back-to-back
    always_comb begin
        tx_state_n = tx_state;
        tx_load    = 1'b0;
        tx_bit_end = (tx_cnt == tx_div - 16'd1);
        case (tx_state)
            TX_IDLE:  tx_load = ~tx_fifo_empty;
            TX_START: if (tx_bit_end) tx_state_n = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bitn == 3'd7) tx_state_n = tx_par_en ? TX_PAR : TX_STOP;
            TX_PAR:   if (tx_bit_end) tx_state_n = TX_STOP;
            TX_STOP:  if (tx_bit_end) begin
                          tx_state_n = TX_IDLE;
                          tx_load    = ~tx_fifo_empty;
                      end
            default:  tx_state_n = TX_IDLE;
        endcase
        if (tx_load) tx_state_n = TX_START;
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            tx_cnt     <= '0;
            tx_div     <= DIV_RST;
            tx_bitn    <= '0;
            tx_shift   <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
            o_uart_txd <= 1'b1;
        end else begin
            if (tx_load) begin
                tx_cnt     <= '0;
                tx_bitn    <= '0;
                tx_shift   <= tx_fifo_dout;
                tx_div     <= div;
                tx_par_en  <= par_en;
                tx_par_bit <= ^tx_fifo_dout ^ par_odd;
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= '0;
                    if (tx_state == TX_DATA) begin
                        tx_bitn  <= tx_bitn + 3'd1;
                        tx_shift <= {1'b0, tx_shift[7:1]};
                    end
                end else begin
                    tx_cnt <= tx_cnt + 16'd1;
                end
            end
            case (tx_state)
                TX_START: o_uart_txd <= 1'b0;
                TX_DATA:  o_uart_txd <= tx_shift[0];
                TX_PAR:   o_uart_txd <= tx_par_bit;
                default:  o_uart_txd <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rxd_s1   <= i_uart_rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
            rx_state <= rx_state_n;
        end
    end

    // start bit is checked at half period; every later bit a full period after that
    always_comb begin
        rx_state_n   = rx_state;
        rx_push      = 1'b0;
        rx_frame_err = 1'b0;
        rx_par_err   = 1'b0;
        rx_tick      = (rx_state == RX_START) ? (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1)
                                              : (rx_cnt == rx_div - 16'd1);
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
            RX_START: if (rx_tick) rx_state_n = rxd_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bitn == 3'd7) rx_state_n = rx_par_en ? RX_PAR : RX_STOP;
            RX_PAR:   if (rx_tick) rx_state_n = RX_STOP;
            RX_STOP:  if (rx_tick) begin
                          rx_state_n = RX_IDLE;
                          if (!rxd_s2)
                              rx_frame_err = 1'b1;
                          else if (rx_par_en && (rx_par_bit != (^rx_shift ^ rx_par_odd)))
                              rx_par_err = 1'b1;
                          else
                              rx_push = 1'b1;
                      end
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            rx_cnt     <= '0;
            rx_div     <= DIV_RST;
            rx_bitn    <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            rx_cnt  <= '0;
            rx_bitn <= '0;
            if (rx_fall) begin
                rx_div     <= div;
                rx_par_en  <= par_en;
                rx_par_odd <= par_odd;
            end
        end else if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_state == RX_DATA) begin
                rx_bitn  <= rx_bitn + 3'd1;
                rx_shift <= {rxd_s2, rx_shift[7:1]};
            end
            if (rx_state == RX_PAR) rx_par_bit <= rxd_s2;
        end else begin
            rx_cnt <= rx_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_uart_fifo_top.sv
// Directed bench for wb_uart_fifo_top: register access, TX framing, loopback,
// RX error paths, TX overflow and mid-frame reset.

module tb_wb_uart_fifo_top;
    logic        clk = 1'b0;
    logic        srst;
    logic [3:0]  wbs_adr;
    logic [31:0] wbs_dat_w, wbs_dat_r;
    logic        wbs_we, wbs_stb, wbs_cyc, wbs_ack;
    logic [3:0]  wbs_sel;
    logic        uart_rxd, uart_txd, irq;
    logic        rx_drv, loop_en;
    logic [0:19] exp_line;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    assign uart_rxd = loop_en ? uart_txd : rx_drv;

    wb_uart_fifo_top #(.p_FDEPTH(16), .p_FREQ(50_000_000), .p_BAUD(115200)) dut (
        .i_clk(clk), .i_srst(srst),
        .iv_wbs_adr(wbs_adr), .iv_wbs_dat(wbs_dat_w), .i_wbs_we(wbs_we),
        .i_wbs_stb(wbs_stb), .iv_wbs_sel(wbs_sel), .i_wbs_cyc(wbs_cyc),
        .ov_wbs_dat(wbs_dat_r), .o_wbs_ack(wbs_ack),
        .i_uart_rxd(uart_rxd), .o_uart_txd(uart_txd), .o_irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we_i, input logic [3:0] a, input logic [31:0] d,
                           output logic [31:0] q);
        int unsigned n;
        @(posedge clk); #1;
        wbs_adr = a; wbs_dat_w = d; wbs_we = we_i; wbs_cyc = 1'b1; wbs_stb = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wbs_ack && n < 8);
        check("wb_ack", {31'd0, wbs_ack}, 32'd1);
        q = wbs_dat_r;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] q);
        wb_xfer(1'b0, a, 32'd0, q);
    endtask

    // bit periods of 8 clocks (DIV=8)
    task automatic send_frame(input logic [7:0] b, input logic with_par, input logic par_bit,
                              input logic stop_bit);
        rx_drv = 1'b0;
        repeat (8) @(posedge clk);
        for (int unsigned i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (8) @(posedge clk);
        end
        if (with_par) begin
            rx_drv = par_bit;
            repeat (8) @(posedge clk);
        end
        rx_drv = stop_bit;
        repeat (8) @(posedge clk);
        rx_drv = 1'b1;
        repeat (16) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        srst = 1'b1; wbs_adr = '0; wbs_dat_w = '0; wbs_we = 1'b0; wbs_stb = 1'b0;
        wbs_cyc = 1'b0; wbs_sel = 4'hF; rx_drv = 1'b1; loop_en = 1'b0;
        // A5 then 3C, start/data LSB-first/stop, in line order
        exp_line = 20'b0101001011_0001111001;
        repeat (5) @(posedge clk);
        #1 srst = 1'b0;

        @(negedge clk);
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_ack", {31'd0, wbs_ack}, 32'd0);
        check("rst_dat", wbs_dat_r, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        wb_read(4'h8, rd); check("rst_ctrl", rd, 32'd434);
        wb_read(4'h4, rd); check("rst_status", rd, 32'h0010_0004);
        wb_read(4'hC, rd); check("rst_err", rd, 32'd0);

        wb_write(4'h8, 32'd2); wb_read(4'h8, rd); check("ctrl_clamp", rd, 32'd4);
        wb_write(4'h8, 32'd8); wb_read(4'h8, rd); check("ctrl_div8", rd, 32'd8);

        fork
            begin
                wb_write(4'h0, 32'hA5);
                wb_write(4'h0, 32'h3C);
            end
            begin : tx_mon
                int unsigned w;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (uart_txd !== 1'b0 && w < 60);
                for (int unsigned i = 0; i < 160; i++) begin
                    if (i != 0) @(negedge clk);
                    if (i % 8 == 0 || i % 8 == 7)
                        check($sformatf("tx_bit%0d_c%0d", i / 8, i % 8), {31'd0, uart_txd},
                              {31'd0, exp_line[i / 8]});
                end
            end
        join
        repeat (4) @(negedge clk);
        check("tx_idle_line", {31'd0, uart_txd}, 32'd1);
        wb_read(4'h4, rd); check("tx_done_status", rd, 32'h0010_0004);
        check("irq_off", {31'd0, irq}, 32'd0);
        wb_write(4'h8, 32'h0020_0008);
        repeat (2) @(posedge clk);
        @(negedge clk); check("irq_txempty", {31'd0, irq}, 32'd1);

        loop_en = 1'b1;
        wb_write(4'h8, 32'h0013_0008);
        wb_read(4'h8, rd); check("ctrl_par_odd", rd, 32'h0013_0008);
        for (int unsigned i = 0; i < 16; i++) wb_write(4'h0, i);
        repeat (1700) @(posedge clk);
        wb_read(4'h4, rd); check("lb_status", rd, 32'h0010_1005);
        @(negedge clk); check("irq_rxne", {31'd0, irq}, 32'd1);
        for (int unsigned i = 0; i < 16; i++) begin
            wb_read(4'h0, rd);
            check($sformatf("lb_byte%0d", i), rd, 32'h8000_0000 | i);
        end
        wb_read(4'hC, rd); check("lb_err", rd, 32'd0);
        wb_read(4'h4, rd); check("lb_status_drained", rd, 32'h0010_0004);
        @(negedge clk); check("irq_rxne_clr", {31'd0, irq}, 32'd0);

        wb_write(4'h8, 32'd8);
        for (int unsigned i = 0; i < 17; i++) wb_write(4'h0, 32'h40 + i);
        repeat (1600) @(posedge clk);
        wb_read(4'hC, rd); check("ovf_err", rd, 32'h1);
        wb_read(4'h4, rd); check("ovf_status", rd, 32'h0010_1005);
        wb_write(4'hC, 32'h1);
        wb_read(4'hC, rd); check("ovf_err_clr", rd, 32'd0);
        for (int unsigned i = 0; i < 16; i++) begin
            wb_read(4'h0, rd);
            check($sformatf("ovf_byte%0d", i), rd, 32'h8000_0040 + i);
        end
        wb_read(4'h4, rd); check("ovf_drained", rd, 32'h0010_0004);

        loop_en = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        wb_read(4'hC, rd); check("frame_err", rd, 32'h2);
        wb_read(4'h4, rd); check("frame_nopush", rd, 32'h0010_0004);
        wb_write(4'hC, 32'hF);
        wb_write(4'h8, 32'h0001_0008);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        wb_read(4'hC, rd); check("parity_err", rd, 32'h4);
        wb_read(4'h4, rd); check("parity_nopush", rd, 32'h0010_0004);
        wb_write(4'hC, 32'hF);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        wb_read(4'h0, rd); check("parity_good_byte", rd, 32'h8000_005A);
        wb_read(4'hC, rd); check("parity_good_err", rd, 32'd0);
        @(posedge clk); rx_drv = 1'b0;
        repeat (2) @(posedge clk); rx_drv = 1'b1;
        repeat (40) @(posedge clk);
        wb_read(4'hC, rd); check("glitch_err", rd, 32'd0);
        wb_read(4'h4, rd); check("glitch_nopush", rd, 32'h0010_0004);

        wb_write(4'h8, 32'd8);
        for (int unsigned i = 0; i < 17; i++) wb_write(4'h0, 32'h00);
        wb_read(4'h4, rd); check("txfull_status", rd, 32'h0000_000A);
        wb_read(4'hC, rd); check("txfull_err", rd, 32'd0);
        wb_write(4'h0, 32'h00);
        wb_read(4'hC, rd); check("txovf_err", rd, 32'h8);
        @(negedge clk); check("txd_midframe", {31'd0, uart_txd}, 32'd0);
        #1 srst = 1'b1;
        @(posedge clk);
        @(negedge clk); check("txd_after_rst", {31'd0, uart_txd}, 32'd1);
        @(posedge clk); #1 srst = 1'b0;
        wb_read(4'h4, rd); check("rst2_status", rd, 32'h0010_0004);
        wb_read(4'hC, rd); check("rst2_err", rd, 32'd0);
        wb_read(4'h8, rd); check("rst2_ctrl", rd, 32'd434);
        repeat (20) @(negedge clk);
        check("rst2_txd_idle", {31'd0, uart_txd}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_uart_fifo_top.md
# wb_uart_fifo_top

Wishbone-slave UART with transmit and receive FIFOs, a runtime-programmable baud divisor, optional parity, error/overflow status and a level interrupt. Sits on the system Wishbone bus as a drop-in, register-compatible successor of the basic UART peripheral. It adds TX buffering, baud/parity control, error reporting and interrupt generation. The TX and RX serial engines are internal; no external UART modules are instantiated.

## Interface
- p_FDEPTH, 16, depth of each FIFO (power of 2, ≥2)
- p_FREQ, 50_000_000, i_clk frequency in Hz
- p_BAUD, 115200, reset baud rate; divisor reset value = p_FREQ/p_BAUD (integer)

Clocking: one clock, i_clk. Reset i_srst is synchronous and active-high.

- i_clk  in  1  system clock
- i_srst  in  1  synchronous active-high reset
- iv_wbs_adr  in  4  byte address; [3:2] select register
- iv_wbs_dat  in  32  write data
- i_wbs_we  in  1  write enable
- i_wbs_stb  in  1  strobe
- iv_wbs_sel  in  4  byte select; ignored, all accesses 32-bit
- i_wbs_cyc  in  1  cycle
- ov_wbs_dat  out  32  read data, valid with ack
- o_wbs_ack  out  1  acknowledge
- i_uart_rxd  in  1  async serial input
- o_uart_txd  out  1  serial output, registered
- o_irq  out  1  level interrupt, active-high

## Operation
Register map:
- 0x0 DATA.
  - Write: push [7:0] into the TX FIFO. If the FIFO is full, the byte is dropped and TX_OVF is set.
  - Read: [7:0] = RX FIFO head, [31] = RX non-empty, other bits 0. The FIFO is popped only if it is non-empty.
- 0x4 STATUS (RO).
  - [0] RX_NE, [1] TX_FULL, [2] TX_EMPTY, [3] TX_BUSY (shifter active).
  - [8+:8] RX count, [16+:8] TX free count.
- 0x8 CTRL (RW).
  - [15:0] DIV: clocks per bit, minimum 4. Writes below 4 are clamped to 4.
  - [16] PAR_EN, [17] PAR_ODD.
  - [20] IE_RXNE, [21] IE_TXEMPTY, [22] IE_ERR.
  - Reset: DIV = p_FREQ/p_BAUD, all other bits 0.
- 0xC ERR (read; write-1-to-clear).
  - [0] RX_OVF, [1] FRAME, [2] PARITY, [3] TX_OVF. All bits are sticky.

Interrupt: o_irq = (IE_RXNE & RX_NE) | (IE_TXEMPTY & TX_EMPTY & ~TX_BUSY) | (IE_ERR & |ERR). It is registered.

TX engine, states IDLE → START → DATA(8 bits, LSB first) → PARITY (only if PAR_EN) → STOP → IDLE.
- Each state lasts DIV clocks.
- IDLE pops the TX FIFO when it is non-empty. The next byte may start in the cycle after STOP ends, so there is no idle gap.
- Parity: even = XOR of the data bits; odd = inverted.
- DIV and the parity settings are latched at the start of each frame.

RX engine:
- i_uart_rxd passes through a 2-flop synchroniser.
- States IDLE → START → DATA → PARITY (optional) → STOP.
- IDLE→START on a synchronised falling edge.
- The start bit is sampled at DIV/2. If it reads high, the engine returns to IDLE (glitch rejected, no error).
- Each following bit is sampled every DIV clocks.
- At STOP:
  - Stop bit low: set FRAME and discard the byte.
  - Parity mismatch: set PARITY and discard the byte.
  - Otherwise push the byte. If the RX FIFO is full, the byte is dropped and RX_OVF is set.
- The engine returns to IDLE right after sampling the stop bit, so it can accept a start edge at once.

FIFOs:
- Each FIFO is synchronous, with pointers that wrap modulo p_FDEPTH and a count of width $clog2(p_FDEPTH)+1.
- A push and a pop in the same cycle are both performed:
  - On a full FIFO: the push is performed, no overflow is flagged, and the count is unchanged.
  - On an empty FIFO: the pop is ignored.
- Read data is first-word-fall-through.

## Timing
Wishbone:
- o_wbs_ack <= i_wbs_cyc & i_wbs_stb & ~o_wbs_ack. This gives 1-cycle latency and one ack per access; back-to-back accesses give an ack every other cycle.
- Register side-effects (push, pop, W1C, CTRL update) happen exactly once per access, in the cycle the ack is registered.
- ov_wbs_dat is registered with the ack and is 0 when ack is low.

Reset values: o_uart_txd=1, o_wbs_ack=0, ov_wbs_dat=0, o_irq=0. Both FIFOs are empty, ERR=0, and both engines are in IDLE.

Reset mid-frame: the frame is aborted, o_uart_txd=1 in the cycle after reset is sampled, and all FIFO contents are lost.

A DIV change during a TX frame affects only the next frame. A DIV change during an RX frame takes effect at the next start bit.

Serial latency: a TXD start edge occurs 2 clocks after the ack of a DATA write to an idle, empty TX FIFO (1 clock for the pop, 1 clock for the output register).

## Test plan
- Reset, then read CTRL → DIV=434 (p_FREQ=50 MHz, p_BAUD=115200). STATUS=0x0010_0004 for p_FDEPTH=16: TX_EMPTY=1, TX free count=16 at [16+:8]. o_uart_txd=1.
- Set DIV=8, no parity, write 0xA5 then 0x3C. On TXD, check bit periods of exactly 8 clocks: frame 0,1,0,1,0,0,1,0,1,1 then the second frame with no gap. After the frames, TX_EMPTY irq asserts when IE_TXEMPTY=1.
- Loop o_uart_txd to i_uart_rxd with PAR_EN=1, PAR_ODD=1. Send 0x00..0x0F. Read 16 bytes in order, each with bit31=1. ERR=0.
- With RX FIFO depth 16, receive 17 bytes without reading → RX_OVF=1, count=16, byte 17 lost. Write ERR=0x1 → RX_OVF cleared.
- Drive a frame with stop bit=0 → FRAME=1, no push. Drive a frame with a flipped parity bit → PARITY=1. A 2-clock low glitch gives no error and no push.
- Write 17 bytes to DATA while TX is idle → 16 queued (the first is popped at once, so 17 accepted when the shifter is free). A further write while full sets TX_OVF. Assert i_srst mid-frame → TXD=1 next cycle and STATUS back to its reset value.
